// File: rtl/jacobi_input_loader_pkg.sv
// Shared constants, widths and FSM state type for the Jacobi input loader.
package jacobi_input_loader_pkg;

    localparam int AXI4_FIFO_WORD_WIDTH     = 32;
    localparam int JACOBI_INPUT_WORD_WIDTH  = 16;
    localparam int JACOBI_OUTPUT_WORD_WIDTH = 20;
    localparam int JACOBI_N                 = 8;
    localparam int JACOBI_N_INPUT_DATA      = 36;
    localparam int JACOBI_V_OFFSET          = 36;
    localparam int JACOBI_ADDR_WIDTH        = 7;
    localparam int JACOBI_V_ONE             = 32768;
    localparam int JACOBI_N_V               = 64;

    typedef enum logic [1:0] {
        LOAD,
        INIT_V,
        START,
        HOLD
    } loader_state_t;

endpackage

// File: rtl/jacobi_input_loader.sv
// Jacobi input loader: streams the upper triangle of a symmetric matrix into
// working memory, widens each value, initialises V to identity, then starts
// the core and waits for the downstream release.
module jacobi_input_loader
    import jacobi_input_loader_pkg::*;
#(
    parameter int AXIS_W = AXI4_FIFO_WORD_WIDTH,
    parameter int IN_W   = JACOBI_INPUT_WORD_WIDTH,
    parameter int OUT_W  = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int N      = JACOBI_N,
    parameter int N_IN   = JACOBI_N_INPUT_DATA,
    parameter int V_OFF  = JACOBI_V_OFFSET,
    parameter int ADDR_W = JACOBI_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AXIS_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [OUT_W-1:0]  mem_wr_data,
    output logic              start,
    input  logic              release_i,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W  = $clog2(N_IN);
    localparam int LN     = $clog2(N);
    localparam int VCNT_W = $clog2(N * N + 1);

    loader_state_t state_q, state_d;

    logic [CNT_W-1:0]  word_cnt;
    logic [VCNT_W-1:0] v_cnt;
    logic [LN-1:0]     v_row, v_col;
    logic              load_state;
    logic              accept;
    logic              last_word;
    logic              v_done;
    logic [OUT_W-1:0]  conv_data;
    logic              unused_tdata_hi;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign last_word = (word_cnt == CNT_W'(N_IN - 1));
    // v_cnt runs one step past the last V write so START lands one cycle
    // after the final registered write has left the write register.
    assign v_done    = (v_cnt == VCNT_W'(N * N));
    assign v_row     = v_cnt[2*LN-1:LN];
    assign v_col     = v_cnt[LN-1:0];

    // Q(1.0.15) -> Q(1.4.15): sign-extend, fraction bits untouched.
    assign conv_data       = {{(OUT_W-IN_W){s_axis_tdata[IN_W-1]}}, s_axis_tdata[IN_W-1:0]};
    assign unused_tdata_hi = ^s_axis_tdata[AXIS_W-1:IN_W];

    // Status outputs are forced low while reset is held.
    assign s_axis_tready = load_state && !rst;
    assign busy          = (state_q != LOAD) && !rst;
    assign start         = (state_q == START) && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and stream-ready decode.
    always_comb begin
        state_d    = state_q;
        load_state = 1'b0;
        unique case (state_q)
            LOAD: begin
                load_state = 1'b1;
                if (accept && last_word) begin
                    state_d = INIT_V;
                end
            end
            INIT_V: begin
                if (v_done) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (release_i) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Word/V counters, registered memory write port and frame error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt    <= '0;
            v_cnt       <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            frame_err   <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            frame_err <= 1'b0;
            if (accept) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= ADDR_W'(word_cnt);
                mem_wr_data <= conv_data;
                if (last_word) begin
                    word_cnt  <= '0;
                    frame_err <= !s_axis_tlast;
                end else if (s_axis_tlast) begin
                    word_cnt  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            if (state_q == INIT_V) begin
                if (!v_done) begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= ADDR_W'(V_OFF) + ADDR_W'(v_cnt);
                    mem_wr_data <= (v_row == v_col) ? OUT_W'(JACOBI_V_ONE) : '0;
                    v_cnt       <= v_cnt + 1'b1;
                end
            end else begin
                v_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jacobi_input_loader.sv
// Self-checking bench for jacobi_input_loader: a cycle-level reference model
// of the loader's observable behaviour plus directed and randomized frames.
module tb_jacobi_input_loader;

    logic        clk;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        mem_wr_en;
    logic [6:0]  mem_wr_addr;
    logic [19:0] mem_wr_data;
    logic        start;
    logic        release_i;
    logic        frame_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    jacobi_input_loader dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .start        (start),
        .release_i    (release_i),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (sampled on the falling edge) ----------
    typedef struct {
        int          due;
        logic [6:0]  addr;
        logic [19:0] data;
    } wr_t;

    wr_t         expq[$];
    logic [19:0] dut_mem [0:127];
    int          cyc       = 0;
    int          k_m       = 0;
    int          phase     = 0;   // 0 accepting, 1 loading V / starting, 2 waiting release
    int          start_due = -1;
    int          ferr_due  = -1;
    logic        rst_prev  = 1'b0;

    always @(negedge clk) begin
        wr_t              w;
        logic signed [15:0] sv;
        int               si;
        logic             exp_ready;
        cyc++;
        exp_ready = !rst && (phase == 0);
        if (expq.size() != 0 && expq[0].due == cyc) begin
            w = expq.pop_front();
            chk("wr_en", mem_wr_en, 1);
            chk("wr_addr", mem_wr_addr, w.addr);
            chk("wr_data", mem_wr_data, w.data);
        end else begin
            chk("wr_en_idle", mem_wr_en, 0);
        end
        if (mem_wr_en === 1'b1) dut_mem[mem_wr_addr] = mem_wr_data;
        chk("start", start, (cyc == start_due));
        chk("frame_err", frame_err, (cyc == ferr_due));
        chk("tready", s_axis_tready, exp_ready);
        chk("busy", busy, !rst && (phase != 0));
        if (rst && rst_prev) begin
            chk("rst_addr", mem_wr_addr, 0);
            chk("rst_data", mem_wr_data, 0);
        end
        if (rst) begin
            expq.delete();
            k_m = 0; phase = 0; start_due = -1; ferr_due = -1;
        end else begin
            case (phase)
                0: if (s_axis_tvalid && exp_ready) begin
                    sv = s_axis_tdata[15:0];
                    si = sv;
                    expq.push_back('{cyc + 1, 7'(k_m), si[19:0]});
                    if (k_m == 35) begin
                        if (!s_axis_tlast) ferr_due = cyc + 1;
                        for (int idx = 0; idx < 64; idx++)
                            expq.push_back('{cyc + 2 + idx, 7'(36 + idx),
                                             (idx / 8 == idx % 8) ? 20'd32768 : 20'd0});
                        start_due = cyc + 66;
                        phase = 1;
                        k_m = 0;
                    end else if (s_axis_tlast) begin
                        ferr_due = cyc + 1;
                        k_m = 0;
                    end else begin
                        k_m++;
                    end
                end
                1: if (cyc == start_due) phase = 2;
                2: if (release_i) phase = 0;
                default: phase = 0;
            endcase
        end
        rst_prev = rst;
    end

    // ---------------- stimulus helpers ----------------------------------------
    logic [31:0] fdata [0:35];
    time         last_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input int from, input int to, input int last_at, input bit gaps);
        bit got;
        for (int i = from; i <= to; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                s_axis_tvalid = 1'b0;
                repeat (g) tick();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fdata[i];
            s_axis_tlast  = (i == last_at);
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                got = (s_axis_tready === 1'b1);
                if (got) last_acc = $time;
                tick();
            end
            chk("accept_timeout", got, 1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_start(input string name);
        bit  found = 1'b0;
        time st = 0;
        for (int t = 0; t < 300 && !found; t++) begin
            @(negedge clk);
            if (start === 1'b1) begin
                found = 1'b1;
                st = $time;
            end
        end
        chk({name, "_start_seen"}, found, 1);
        if (found) chk({name, "_latency"}, 32'((st - last_acc) / 10), 66);
        tick();
    endtask

    task automatic pulse_release();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
    endtask

    // ---------------- conversion vectors -------------------------------------
    typedef struct {
        logic [31:0] tdata;
        logic [19:0] exp_data;
    } conv_vec_t;

    conv_vec_t tbl [0:6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0000_8000, 20'hF8000};
        tbl[1] = '{32'hFFFF_7FFF, 20'h07FFF};
        tbl[2] = '{32'h0000_0000, 20'h00000};
        tbl[3] = '{32'hFFFF_FFFF, 20'hFFFFF};
        tbl[4] = '{32'h1234_0001, 20'h00001};
        tbl[5] = '{32'hABCD_8001, 20'hF8001};
        tbl[6] = '{32'h5555_4000, 20'h04000};

        rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; release_i = 1'b0;
        last_acc = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_tready", s_axis_tready, 0);
        chk("reset_wr_en", mem_wr_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_start", start, 0);
        chk("reset_frame_err", frame_err, 0);
        tick();
        rst = 1'b0;

        // Frame A: data = k
        for (int i = 0; i < 36; i++) fdata[i] = 32'(i);
        send_words(0, 35, 35, 0);
        wait_start("frame_a");
        for (int i = 0; i < 36; i++) chk("a_tri", dut_mem[i], 20'(i));
        chk("v36", dut_mem[36], 20'h08000);
        chk("v37", dut_mem[37], 20'h00000);
        chk("v45", dut_mem[45], 20'h08000);
        chk("v99", dut_mem[99], 20'h08000);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                chk("v_all", dut_mem[36 + 8 * r + c], (r == c) ? 20'h08000 : 20'h0);

        // Frame B: tvalid held through HOLD, release, then conversion vectors
        for (int i = 0; i < 36; i++) fdata[i] = $urandom;
        s_axis_tvalid = 1'b1; s_axis_tdata = fdata[0]; s_axis_tlast = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_tready", s_axis_tready, 0);
            tick();
        end
        pulse_release();
        @(negedge clk);
        chk("tready_after_release", s_axis_tready, 1);
        last_acc = $time;
        tick();
        s_axis_tvalid = 1'b0;
        for (int v = 0; v < 7; v++) begin
            fdata[v + 1] = tbl[v].tdata;
            send_words(v + 1, v + 1, 35, 0);
            @(negedge clk);
            chk("conv_data", mem_wr_data, tbl[v].exp_data);
            chk("conv_addr", mem_wr_addr, 32'(v + 1));
            tick();
        end
        send_words(8, 35, 35, 0);
        wait_start("frame_b");
        pulse_release();

        // Frame C: release held during V initialisation and the start pulse
        for (int i = 0; i < 36; i++) fdata[i] = $urandom;
        send_words(0, 35, 35, 0);
        release_i = 1'b1;
        wait_start("frame_c");
        release_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_after_release_in_init", s_axis_tready, 0);
            tick();
        end
        pulse_release();

        // Early tlast on beat 10, then a clean frame
        for (int i = 0; i < 36; i++) fdata[i] = $urandom;
        send_words(0, 10, 10, 0);
        @(negedge clk);
        chk("early_tlast_err", frame_err, 1);
        tick();
        for (int i = 0; i < 36; i++) fdata[i] = $urandom;
        send_words(0, 35, 35, 0);
        wait_start("after_early_tlast");
        pulse_release();

        // Missing tlast on beat 35
        for (int i = 0; i < 36; i++) fdata[i] = $urandom;
        send_words(0, 35, -1, 0);
        @(negedge clk);
        chk("missing_tlast_err", frame_err, 1);
        tick();
        wait_start("missing_tlast");
        pulse_release();

        // Random frames with tvalid gaps
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 36; i++) fdata[i] = $urandom;
            send_words(0, 35, 35, 1);
            wait_start("random");
            pulse_release();
        end

        // Reset mid-frame, then a full frame
        for (int i = 0; i < 36; i++) fdata[i] = $urandom;
        send_words(0, 19, -1, 0);
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("midrst_tready", s_axis_tready, 0);
        chk("midrst_wr_en", mem_wr_en, 0);
        chk("midrst_addr", mem_wr_addr, 0);
        chk("midrst_data", mem_wr_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", start, 0);
        chk("midrst_frame_err", frame_err, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 36; i++) fdata[i] = $urandom;
        send_words(0, 35, 35, 0);
        wait_start("after_reset");
        pulse_release();
        repeat (3) tick();

        chk("pending_writes", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
